mem_stage: RTL and testbench

//  Memory-access pipeline stage, directly downstream of the execute stage.

---
 rtl/mem_stage_if.sv | 34 +++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute-side, data-memory and write-back signals of the memory stage
interface mem_stage_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic [2:0]    i_ctrl_mux;
  logic [DW-1:0] i_aluout;
  logic [DW-1:0] i_b;
  logic [4:0]    i_rd;
  logic          o_stall;
  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          o_valid;
  logic          o_we;
  logic [DW-1:0] o_wdata;
  logic [4:0]    o_rd;
  logic          o_err;

  // Environment side: drives execute outputs and memory responses.
  modport master (
    output i_valid, i_ctrl_mux, i_aluout, i_b, i_rd, dm_rdata, dm_ack,
    input  o_stall, dm_req, dm_we, dm_addr, dm_wdata, o_valid, o_we, o_wdata, o_rd, o_err
  );

  // Stage side.
  modport slave (
    input  i_valid, i_ctrl_mux, i_aluout, i_b, i_rd, dm_rdata, dm_ack,
    output o_stall, dm_req, dm_we, dm_addr, dm_wdata, o_valid, o_we, o_wdata, o_rd, o_err
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ack data port and access timeout
module mem_stage #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic          we_q;

  logic          is_load;
  logic          is_store;
  logic          misaligned;

  assign is_load    = bus.i_ctrl_mux[2];
  assign is_store   = bus.i_ctrl_mux[1];
  assign misaligned = (bus.i_aluout[1:0] != 2'b00);

  // Upstream stalls for exactly as long as an access is outstanding.
  assign bus.o_stall = (state == ACCESS);

  // Control FSM with registered memory-port and write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      bus.dm_req   <= 1'b0;
      bus.dm_we    <= 1'b0;
      bus.dm_addr  <= '0;
      bus.dm_wdata <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_we     <= 1'b0;
      bus.o_wdata  <= '0;
      bus.o_rd     <= '0;
      bus.o_err    <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            if (!is_load && !is_store) begin
              // Plain ALU result passes straight through.
              bus.o_valid <= 1'b1;
              bus.o_wdata <= bus.i_aluout;
              bus.o_rd    <= bus.i_rd;
              bus.o_we    <= bus.i_ctrl_mux[0];
            end else if ((is_load && is_store) || misaligned) begin
              // Illegal control or unaligned address: report without touching memory.
              bus.o_valid <= 1'b1;
              bus.o_err   <= 1'b1;
              bus.o_we    <= 1'b0;
              bus.o_wdata <= bus.i_aluout;
              bus.o_rd    <= bus.i_rd;
            end else begin
              bus.dm_addr  <= bus.i_aluout;
              bus.dm_wdata <= bus.i_b;
              bus.dm_we    <= is_store;
              bus.dm_req   <= 1'b1;
              rd_q         <= bus.i_rd;
              we_q         <= bus.i_ctrl_mux[0];
              cnt          <= '0;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus.dm_ack) begin
            // Acknowledge wins even on the final allowed cycle.
            bus.dm_req  <= 1'b0;
            bus.o_valid <= 1'b1;
            bus.o_rd    <= rd_q;
            state       <= IDLE;
            if (bus.dm_we) begin
              bus.o_wdata <= bus.dm_addr;
              bus.o_we    <= 1'b0;
            end else begin
              bus.o_wdata <= bus.dm_rdata;
              bus.o_we    <= we_q;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.dm_req  <= 1'b0;
            bus.o_valid <= 1'b1;
            bus.o_err   <= 1'b1;
            bus.o_we    <= 1'b0;
            bus.o_rd    <= rd_q;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven and randomized self-checking bench for mem_stage
module tb_mem_stage;

  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  mem_stage_if #(.DW(DW)) bus ();

  mem_stage #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rd;
    int          delay;   // ACCESS cycle (1-based) carrying dm_ack; 0 = never
    logic [31:0] rdata;
    logic        e_err;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    int          e_req;   // expected number of cycles dm_req is high
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Outcome derived directly from the stage's rules, per transaction.
  function automatic vec_t model(input logic [2:0] ctrl, input logic [31:0] alu, input logic [31:0] b,
                                 input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    vec_t v;
    v.ctrl = ctrl; v.alu = alu; v.b = b; v.rd = rd; v.delay = delay; v.rdata = rdata;
    v.e_rd = rd; v.e_wdata = 32'h0; v.e_we = 1'b0; v.e_err = 1'b0; v.e_req = 0;
    if (ctrl[2:1] == 2'b00) begin
      v.e_wdata = alu;
      v.e_we    = ctrl[0];
    end else if (ctrl[2:1] == 2'b11 || (alu % 4) != 0) begin
      v.e_err = 1'b1;
    end else if (delay < 1 || delay > TIMEOUT) begin
      v.e_err = 1'b1;
      v.e_req = TIMEOUT;
    end else begin
      v.e_req = delay;
      if (ctrl[2]) begin
        v.e_wdata = rdata;
        v.e_we    = ctrl[0];
      end else begin
        v.e_wdata = alu;
      end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  req_n;
    bit  stall_ok;
    bus.i_valid    = 1'b1;
    bus.i_ctrl_mux = v.ctrl;
    bus.i_aluout   = v.alu;
    bus.i_b        = v.b;
    bus.i_rd       = v.rd;
    @(posedge clk); #1;
    bus.i_valid    = 1'b0;
    bus.i_ctrl_mux = 3'($urandom);
    bus.i_aluout   = $urandom;
    if (v.e_req > 0) begin
      chk({tag, " dm_we"},    {31'b0, bus.dm_we}, {31'b0, v.ctrl[1]});
      chk({tag, " dm_addr"},  bus.dm_addr, v.alu);
      chk({tag, " dm_wdata"}, bus.dm_wdata, v.b);
    end
    req_n    = 0;
    stall_ok = 1'b1;
    while (bus.dm_req && req_n < TIMEOUT + 4) begin
      req_n++;
      if (bus.o_stall !== 1'b1) stall_ok = 1'b0;
      if (req_n == v.delay) begin
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = v.rdata;
      end
      @(posedge clk); #1;
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = $urandom;
    end
    chk({tag, " req_cycles"}, 32'(req_n), 32'(v.e_req));
    chk({tag, " stall_during"}, {31'b0, stall_ok}, 32'd1);
    chk({tag, " o_valid"}, {31'b0, bus.o_valid}, 32'd1);
    chk({tag, " o_err"},   {31'b0, bus.o_err},   {31'b0, v.e_err});
    chk({tag, " o_we"},    {31'b0, bus.o_we},    {31'b0, v.e_we});
    chk({tag, " o_stall"}, {31'b0, bus.o_stall}, 32'd0);
    if (!v.e_err) begin
      chk({tag, " o_wdata"}, bus.o_wdata, v.e_wdata);
      chk({tag, " o_rd"},    {27'b0, bus.o_rd}, {27'b0, v.e_rd});
    end
    // A stray acknowledge while idle must have no effect.
    bus.dm_ack = 1'($urandom);
    @(posedge clk); #1;
    bus.dm_ack = 1'b0;
    chk({tag, " pulse_end"}, {31'b0, bus.o_valid}, 32'd0);
    chk({tag, " idle_req"},  {31'b0, bus.dm_req},  32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{3'b001, 32'h1234,     32'h0,    5'd5,  0, 32'h0,        1'b0, 1'b1, 32'h1234,     5'd5,  0};
    tbl[1] = '{3'b000, 32'hFFFFFFFF, 32'h0,    5'd31, 0, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF, 5'd31, 0};
    tbl[2] = '{3'b101, 32'h40,       32'h0,    5'd7,  3, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 5'd7,  3};
    tbl[3] = '{3'b010, 32'h80,       32'hCAFE, 5'd9,  1, 32'h55,       1'b0, 1'b0, 32'h80,       5'd9,  1};
    tbl[4] = '{3'b101, 32'h42,       32'h0,    5'd3,  1, 32'h0,        1'b1, 1'b0, 32'h0,        5'd3,  0};
    tbl[5] = '{3'b110, 32'h40,       32'h0,    5'd2,  1, 32'h0,        1'b1, 1'b0, 32'h0,        5'd2,  0};
    tbl[6] = '{3'b101, 32'h100,      32'h0,    5'd4,  0, 32'h0,        1'b1, 1'b0, 32'h0,        5'd4,  16};
    tbl[7] = '{3'b100, 32'h104,      32'h0,    5'd6,  16, 32'h1357,    1'b0, 1'b0, 32'h1357,     5'd6,  16};
    tbl[8] = '{3'b011, 32'h83,       32'h1,    5'd8,  1, 32'h0,        1'b1, 1'b0, 32'h0,        5'd8,  0};

    bus.i_valid = 1'b0; bus.i_ctrl_mux = 3'b0; bus.i_aluout = '0; bus.i_b = '0; bus.i_rd = '0;
    bus.dm_rdata = '0; bus.dm_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("reset dm_req",  {31'b0, bus.dm_req},  32'd0);
    chk("reset o_stall", {31'b0, bus.o_stall}, 32'd0);
    chk("reset o_wdata", bus.o_wdata, 32'd0);
    chk("reset dm_addr", bus.dm_addr, 32'd0);
    chk("reset o_err",   {31'b0, bus.o_err},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back ALU ops, one per cycle.
    bus.i_ctrl_mux = 3'b001;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_aluout = 32'h100 + 32'(i);
      bus.i_rd     = 5'(i + 1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d o_valid", i), {31'b0, bus.o_valid}, 32'd1);
      chk($sformatf("b2b%0d o_wdata", i), bus.o_wdata, 32'h100 + 32'(i));
      chk($sformatf("b2b%0d o_rd", i), {27'b0, bus.o_rd}, 32'(i + 1));
    end
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b end o_valid", {31'b0, bus.o_valid}, 32'd0);

    // Reset during the second ACCESS cycle; a later ack must be ignored.
    bus.i_valid = 1'b1; bus.i_ctrl_mux = 3'b101; bus.i_aluout = 32'h200; bus.i_rd = 5'd10;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("rstmid req1", {31'b0, bus.dm_req}, 32'd1);
    @(posedge clk); #1;
    chk("rstmid req2", {31'b0, bus.dm_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid req_drop", {31'b0, bus.dm_req},  32'd0);
    chk("rstmid stall",    {31'b0, bus.o_stall}, 32'd0);
    chk("rstmid o_valid",  {31'b0, bus.o_valid}, 32'd0);
    bus.dm_ack = 1'b1; bus.dm_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus.dm_ack = 1'b0;
    chk("rstmid late_ack o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rstmid late_ack dm_req",  {31'b0, bus.dm_req},  32'd0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  c;
      logic [31:0] a;
      int          d;
      c = 3'($urandom);
      a = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      d = $urandom_range(0, TIMEOUT + 2);
      run_vec(model(c, a, $urandom, 5'($urandom), d, $urandom), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
